// File: rtl/rot_imm_encoder_pkg.sv
// Shared definitions for the ARM rotated-immediate encoder: FSM encoding
// and the rotation/immediate field sizes.
package rot_imm_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int ROT_MAX = 15;
  localparam int IMM_W   = 8;

endpackage

// File: rtl/rot_imm_encoder_rotl32.sv
// Combinational 32-bit rotate-left by a 5-bit amount.
module rotl32 (
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  output logic [31:0] result
);

  logic [63:0] doubled;

  // Shifting the doubled word left wraps the high bits back in from the copy.
  assign doubled = {data, data} << amount;
  assign result  = doubled[63:32];

endmodule

// File: rtl/rot_imm_encoder.sv
// Searches rotations 0..30 (step 2) for the smallest one that brings a
// 32-bit constant into an 8-bit immediate, producing {rot, imm8}.
module rot_imm_encoder
  import rot_imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shift_operand
);

  state_t      state;
  logic [3:0]  k;
  logic [31:0] value_q;
  logic [31:0] candidate;
  logic [4:0]  amount;
  logic        match;

  assign amount = {k, 1'b0};
  assign match  = (candidate[31:IMM_W] == '0);

  rotl32 u_rotl32 (
    .data   (value_q),
    .amount (amount),
    .result (candidate)
  );

  // Results are only written on entry to DONE, so they hold steady
  // throughout a search and until the next one completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= 4'd0;
      value_q       <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      shift_operand <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            value_q <= value;
            k       <= 4'd0;
            busy    <= 1'b1;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          if (match) begin
            found         <= 1'b1;
            shift_operand <= {k, candidate[IMM_W-1:0]};
            done          <= 1'b1;
            state         <= DONE;
          end else if (k == 4'(ROT_MAX)) begin
            found         <= 1'b0;
            shift_operand <= 12'h000;
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            k <= k + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rot_imm_encoder.md
ROT_IMM_ENCODER -- requirements
Module: rot_imm_encoder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to encode value; accepted only in IDLE.
REQ-004 The block SHALL have the port value, input, 32 bits: constant to encode; sampled only on the accepting cycle.
REQ-005 The block SHALL have the port busy, output, 1 bit: high in SEARCH and DONE.
REQ-006 The block SHALL have the port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-007 The block SHALL have the port found, output, 1 bit: value is representable as an ARM rotated immediate.
REQ-008 The block SHALL have the port shift_operand, output, 12 bits: {rot[3:0], imm8[7:0]}, where ROR(imm8, 2*rot) == value.

Function
REQ-009 The block SHALL have exactly three states: IDLE, SEARCH and DONE.
REQ-010 In IDLE with start=1 (cycle T), the block SHALL latch value, clear the rotation counter k to 0 and enter SEARCH at T+1.
REQ-011 In SEARCH, each cycle SHALL test candidate c = ROL(latched value, 2*k); a match is c[31:8]==0.
REQ-012 On a match, the block SHALL register found=1 and shift_operand={k, c[7:0]}, then enter DONE next cycle.
REQ-013 With no match and k<15, k SHALL increment by 1 and the block SHALL remain in SEARCH.
REQ-014 With no match and k==15, the block SHALL register found=0 and shift_operand=12'h000, then enter DONE.
REQ-015 The first match (smallest k) SHALL win, so the encoding is canonical.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 done SHALL occur at cycle T+2+k for a match at k, and at T+17 when no match exists.
REQ-018 found and shift_operand SHALL hold their values from DONE until the next accepted start, and SHALL not change while SEARCH is in progress.
REQ-019 start SHALL be ignored in SEARCH and DONE; it is not queued.
REQ-020 value changes after the accepting cycle SHALL not affect the result.
REQ-021 value=0 SHALL encode as found=1, shift_operand=12'h000, with done at T+2.
REQ-022 k SHALL be 4 bits wide and never wrap; the rotate amount 2*k SHALL be computed 5 bits wide (0..30).
REQ-023 The inverse relation SHALL hold: feeding the result to the codebase's val2 generator (imm=1, memInst=0) reproduces value exactly.

Reset
REQ-024 Reset SHALL force: state=IDLE, k=0, busy=0, done=0, found=0, shift_operand=12'h000, latched value=0.
REQ-025 Reset asserted mid-SEARCH or in DONE SHALL abort the operation with no done pulse; start is accepted in the first cycle after rst deasserts.
REQ-026 If rst and start are both high in the same cycle, rst SHALL win and start SHALL be dropped.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2) and the constants ROT_MAX=15 and IMM_W=8.
REQ-028 The block SHALL contain one combinational sub-module, rotl32 (32-bit data, 5-bit amount, rotate-left), used for the candidate.
REQ-029 There SHALL be no other sub-modules; the FSM, counter and result registers SHALL live in rot_imm_encoder.

Verification
REQ-030 value=32'h000000FF -> found=1, shift_operand=12'h0FF, done at T+2.
REQ-031 value=32'hF000000F -> found=1, shift_operand=12'h2FF, done at T+4; value=32'hFF000000 -> found=1, shift_operand=12'h4FF, done at T+6.
REQ-032 value=32'h00000104 -> found=1, shift_operand=12'hF41, done at T+17.
REQ-033 value=32'h00000101 -> found=0, shift_operand=12'h000, done at T+17; a second start pulse at T+5 is ignored.
REQ-034 rst=1 at T+3 during the search of 32'h00000104 -> no done pulse, all outputs 0; a new start with 32'h0 gives done two cycles after acceptance.
REQ-035 Randomised loop: every found=1 result re-expanded via ROR equals value; every found=0 case is confirmed unencodable by an exhaustive model.
